iir_biquad_cascade: RTL and testbench

Parametrised, time-multiplexed cascade of Direct Form I biquad IIR sections, with runtime-loadable coefficients and a valid/ready sample handshake. A single shared multiply-accumulator processes the sections sequentially. It generalises the fixed single-filter phase-corrector IIR path to N sections. It sits in the TP3 phase-corrector datapath between the sample source and the downstream correction stage.

---
 rtl/iir_biquad_cascade.sv | 177 +++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade
//   Time-multiplexed cascade of N_SECTIONS Direct Form I biquads sharing a
//   single multiply-accumulator. One tap is processed per cycle (b0,b1,b2,a1,a2)
//   followed by one write-back cycle per section, so a sample takes
//   6*N_SECTIONS cycles from accept to o_valid.
//
//   Section: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2
//   Coefficient address = 5*sec + k, k: 0 b0, 1 b1, 2 b2, 3 a1, 4 a2.
//
//   Optional build macro IIR_SAT_EN: saturate the rounded section result to
//   NB_DATA bits; when undefined the result wraps (low NB_DATA bits kept).
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_valid, i_data    input sample, accepted when i_valid & o_ready
//   o_ready            high while idle (low during reset)
//   i_coeff_we/addr/data  coefficient write port, honoured only when idle
//   o_valid, o_data    one-cycle output strobe, o_data held between strobes
module iir_biquad_cascade #(
  parameter int NB_DATA    = 16,
  parameter int NB_COEFF   = 16,
  parameter int NB_FRAC    = 14,
  parameter int N_SECTIONS = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_valid,
  input  logic signed [NB_DATA-1:0]             i_data,
  output logic                                  o_ready,
  input  logic                                  i_coeff_we,
  input  logic [$clog2(5*N_SECTIONS)-1:0]       i_coeff_addr,
  input  logic signed [NB_COEFF-1:0]            i_coeff_data,
  output logic                                  o_valid,
  output logic signed [NB_DATA-1:0]             o_data
);

  localparam int N_COEF = 5 * N_SECTIONS;
  localparam int ADDR_W = $clog2(N_COEF);
  localparam int SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam int PROD_W = NB_DATA + NB_COEFF;
  // Five full-scale products need at most 3 guard bits.
  localparam int ACC_W  = NB_DATA + NB_COEFF + 3;

  localparam logic signed [NB_COEFF-1:0] UNITY    = NB_COEFF'(1) << NB_FRAC;
  localparam logic signed [ACC_W-1:0]    RND_HALF = ACC_W'(1) << (NB_FRAC - 1);
  localparam logic signed [ACC_W-1:0]    SAT_MAX  = ACC_W'(2 ** (NB_DATA - 1) - 1);
  localparam logic signed [ACC_W-1:0]    SAT_MIN  = ACC_W'(-(2 ** (NB_DATA - 1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  state_t                     state_q, state_d;
  logic [SEC_W-1:0]           sec_q;
  logic [2:0]                 tap_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [NB_DATA-1:0]  x_in_q;
  logic signed [NB_COEFF-1:0] coeff_q [N_COEF];
  logic signed [NB_DATA-1:0]  x1_q [N_SECTIONS];
  logic signed [NB_DATA-1:0]  x2_q [N_SECTIONS];
  logic signed [NB_DATA-1:0]  y1_q [N_SECTIONS];
  logic signed [NB_DATA-1:0]  y2_q [N_SECTIONS];

  logic                       accept;
  logic                       last_sec;
  logic [2:0]                 tap_idx;
  logic [ADDR_W-1:0]          coef_idx;
  logic signed [NB_DATA-1:0]  opnd;
  logic signed [NB_COEFF-1:0] coef;
  logic signed [PROD_W-1:0]   prod;
  logic signed [NB_DATA-1:0]  r;

  function automatic logic signed [ACC_W-1:0] round_frac(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + RND_HALF;
    return t >>> NB_FRAC;
  endfunction

  function automatic logic signed [NB_DATA-1:0] reduce_data(input logic signed [ACC_W-1:0] v);
`ifdef IIR_SAT_EN
    if (v > SAT_MAX)      return SAT_MAX[NB_DATA-1:0];
    else if (v < SAT_MIN) return SAT_MIN[NB_DATA-1:0];
    else                  return v[NB_DATA-1:0];
`else
    return v[NB_DATA-1:0];
`endif
  endfunction

  assign o_ready  = (state_q == S_IDLE) && !i_rst;
  assign accept   = i_valid && o_ready;
  assign last_sec = (sec_q == SEC_W'(N_SECTIONS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MAC;
      S_MAC:   if (tap_q == 3'd4) state_d = S_WB;
      S_WB:    state_d = last_sec ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC operand/coefficient select; tap index clamped so WB never reads past the RAM.
  always_comb begin
    tap_idx  = (tap_q > 3'd4) ? 3'd4 : tap_q;
    coef_idx = ADDR_W'(sec_q) * ADDR_W'(5) + ADDR_W'(tap_idx);
    coef     = coeff_q[coef_idx];
    case (tap_idx)
      3'd1:    opnd = x1_q[sec_q];
      3'd2:    opnd = x2_q[sec_q];
      3'd3:    opnd = y1_q[sec_q];
      3'd4:    opnd = y2_q[sec_q];
      default: opnd = x_in_q;
    endcase
    prod = PROD_W'(opnd) * PROD_W'(coef);
    r    = reduce_data(round_frac(acc_q));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sec_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      x_in_q  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      for (int s = 0; s < N_SECTIONS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
      for (int i = 0; i < N_COEF; i++) begin
        coeff_q[i] <= (i % 5 == 0) ? UNITY : '0;
      end
    end else begin
      state_q <= state_d;
      o_valid <= 1'b0;
      if (i_coeff_we && (state_q == S_IDLE) && (i_coeff_addr < ADDR_W'(N_COEF))) begin
        coeff_q[i_coeff_addr] <= i_coeff_data;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_in_q <= i_data;
            sec_q  <= '0;
            tap_q  <= '0;
            acc_q  <= '0;
          end
        end
        // Accumulate one tap; feedback taps (a1, a2) are subtracted.
        S_MAC: begin
          if (tap_q >= 3'd3) acc_q <= acc_q - ACC_W'(prod);
          else               acc_q <= acc_q + ACC_W'(prod);
          tap_q <= tap_q + 3'd1;
        end
        // Write back section state; result feeds the next section or the output.
        S_WB: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_in_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= r;
          x_in_q      <= r;
          if (last_sec) begin
            o_data  <= r;
            o_valid <= 1'b1;
          end else begin
            sec_q <= sec_q + SEC_W'(1);
            tap_q <= '0;
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade
//   Self-checking bench for iir_biquad_cascade at default parameters.
//   Expected outputs are queued when a sample is accepted and compared when
//   o_valid fires; a behavioural cascade model supplies expectations for the
//   random-coefficient sequence. Honours IIR_SAT_EN the same way as the design.
module tb_iir_biquad_cascade;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_ready;
  logic        i_coeff_we = 1'b0;
  logic [4:0]  i_coeff_addr = '0;
  logic [15:0] i_coeff_data = '0;
  logic        o_valid;
  logic [15:0] o_data;

  int checks = 0;
  int failures = 0;
  int vld_seen = 0;
  logic [15:0] exp_q[$];

  // behavioural model state
  int mc [5*NS];
  int mx1 [NS];
  int mx2 [NS];
  int my1 [NS];
  int my2 [NS];

  typedef struct {
    logic [15:0] din;
    logic [15:0] dexp;
  } vec_t;

  vec_t        pt_vec [6];
  logic [15:0] rec_exp [6];
  logic [15:0] prev_out;
  logic [15:0] rc;
  logic [15:0] sat_exp;
  int          e;
  int          v0;
  int          n;

  iir_biquad_cascade #(
    .NB_DATA(16), .NB_COEFF(16), .NB_FRAC(14), .N_SECTIONS(NS)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_ready(o_ready),
    .i_coeff_we(i_coeff_we),
    .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data),
    .o_valid(o_valid),
    .o_data(o_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vld_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid actual=%h required=none", o_data);
      end else begin
        logic [15:0] ex;
        ex = exp_q.pop_front();
        if (o_data !== ex) begin
          failures++;
          $display("FAIL output actual=%h required=%h", o_data, ex);
        end
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 5*NS; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
    for (int s = 0; s < NS; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic int model_step(input int x);
    int     xi;
    int     r;
    longint acc;
    xi = x;
    for (int s = 0; s < NS; s++) begin
      acc = longint'(mc[5*s]) * xi + longint'(mc[5*s+1]) * mx1[s]
          + longint'(mc[5*s+2]) * mx2[s] - longint'(mc[5*s+3]) * my1[s]
          - longint'(mc[5*s+4]) * my2[s];
      acc = (acc + 64'sd8192) >>> 14;
`ifdef IIR_SAT_EN
      if (acc > 32767)       r = 32767;
      else if (acc < -32768) r = -32768;
      else                   r = int'(acc);
`else
      r = int'($signed(acc[15:0]));
`endif
      mx2[s] = mx1[s]; mx1[s] = xi;
      my2[s] = my1[s]; my1[s] = r;
      xi = r;
    end
    return xi;
  endfunction

  // Called at posedge+1; returns at posedge+1 after release.
  task automatic apply_reset(input int cyc);
    i_rst = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd0);
    end
    i_rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(o_ready), 32'd1);
    model_reset();
  endtask

  task automatic write_coeff(input logic [4:0] a, input logic [15:0] d);
    i_coeff_we = 1'b1; i_coeff_addr = a; i_coeff_data = d;
    @(posedge clk); #1;
    i_coeff_we = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (o_ready !== 1'b1 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 500) chk("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  // Drives one sample and returns at posedge+1 after the accept edge.
  task automatic send(input logic [15:0] x, input logic [15:0] ex, input bit push);
    wait_ready();
    if (push) exp_q.push_back(ex);
    i_valid = 1'b1; i_data = x;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_ready !== 1'b1) && k < 600) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_in_time", 32'(k < 600), 32'd1);
  endtask

  initial begin
    pt_vec[0] = '{16'h0000, 16'h0000};
    pt_vec[1] = '{16'h7FFF, 16'h7FFF};
    pt_vec[2] = '{16'h8000, 16'h8000};
    pt_vec[3] = '{16'hFFFF, 16'hFFFF};
    pt_vec[4] = '{16'h0001, 16'h0001};
    pt_vec[5] = '{16'hC3A5, 16'hC3A5};
    rec_exp[0] = 16'h4000; rec_exp[1] = 16'h2000; rec_exp[2] = 16'h1000;
    rec_exp[3] = 16'h0800; rec_exp[4] = 16'h0400; rec_exp[5] = 16'h0200;
`ifdef IIR_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hA800;
`endif
    model_reset();

    // reset and passthrough latency
    #1;
    apply_reset(3);
    prev_out = o_data;
    send(16'h1234, 16'h1234, 1'b1);
    for (int c = 1; c <= 6*NS; c++) begin
      @(posedge clk); #1;
      if (c < 6*NS) begin
        chk("lat_valid_low", 32'(o_valid), 32'd0);
        chk("lat_ready_low", 32'(o_ready), 32'd0);
        chk("lat_data_hold", 32'(o_data), 32'(prev_out));
      end else begin
        chk("lat_valid_high", 32'(o_valid), 32'd1);
        chk("lat_data", 32'(o_data), 32'h1234);
        chk("lat_ready_back", 32'(o_ready), 32'd1);
      end
    end
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(o_valid), 32'd0);
    chk("data_held", 32'(o_data), 32'h1234);

    // passthrough vectors, back-to-back
    for (int i = 0; i < 6; i++) send(pt_vec[i].din, pt_vec[i].dexp, 1'b1);
    drain();

    // recursion: section 0 a1 = -0.5, impulse then zeros
    apply_reset(1);
    write_coeff(5'd3, 16'hE000);
    for (int i = 0; i < 6; i++) send((i == 0) ? 16'h4000 : 16'h0000, rec_exp[i], 1'b1);
    drain();

    // saturation / wrap on section 0 with b0 = 1.5
    apply_reset(1);
    write_coeff(5'd0, 16'h6000);
    send(16'h7000, sat_exp, 1'b1);
    drain();

    // busy-time write and sample are both dropped
    apply_reset(1);
    send(16'd1000, 16'd1000, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    i_coeff_we = 1'b1; i_coeff_addr = 5'd0; i_coeff_data = 16'h2000;
    i_valid = 1'b1; i_data = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      chk("busy_ready_low", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_coeff_we = 1'b0; i_valid = 1'b0;
    drain();
    write_coeff(5'd0, 16'h2000);
    send(16'd1000, 16'd500, 1'b1);
    send(16'hF830, 16'hFC18, 1'b1);
    drain();

    // reset mid-computation (b0 = 0.5 still loaded)
    send(16'h1234, 16'h0000, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    v0 = vld_seen;
    apply_reset(2);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_no_valid", 32'(vld_seen - v0), 32'd0);
    send(16'h0100, 16'h0100, 1'b1);
    drain();

    // random coefficients and inputs against the behavioural model
    apply_reset(1);
    for (int i = 0; i < 5*NS; i++) begin
      rc = 16'($urandom_range(0, 65535));
      if (i % 5 >= 3) rc = 16'($signed(rc) >>> 2);
      mc[i] = int'($signed(rc));
      write_coeff(5'(i), rc);
    end
    for (int i = 0; i < 8; i++) begin
      rc = 16'($urandom_range(0, 65535));
      e = model_step(int'($signed(rc)));
      send(rc, 16'(e), 1'b1);
    end
    // coefficient write in the same cycle as an accept is used for that sample
    wait_ready();
    rc = 16'h3000;
    mc[0] = int'($signed(rc));
    e = model_step(16'sh0400);
    exp_q.push_back(16'(e));
    i_valid = 1'b1; i_data = 16'h0400;
    i_coeff_we = 1'b1; i_coeff_addr = 5'd0; i_coeff_data = rc;
    @(posedge clk); #1;
    i_valid = 1'b0; i_coeff_we = 1'b0;
    drain();

    n = exp_q.size();
    chk("queue_empty", 32'(n), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
